clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CW, default 16: divisor/counter width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 12: divisor loaded at reset, i.e. the 8051 machine cycle.
REQ-004 SHALL have port CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  in  NCH  per-channel run enable.
REQ-007 SHALL have port sync  in  1  single-cycle restart of all channels.
REQ-008 SHALL have port wr  in  1  divisor write strobe.
REQ-009 SHALL have port wr_ch  in  max(1,clog2(NCH))  target channel of the write.
REQ-010 SHALL have port wr_div  in  CW  new divisor value.
REQ-011 SHALL have port tick  out  NCH  one-cycle pulse per channel period.
REQ-012 SHALL have port clk_out  out  NCH  square wave, period equal to the divisor.
REQ-013 SHALL have port pending  out  NCH  staged divisor not yet applied.

Function
REQ-014 SHALL treat an effective divisor d as max(div,1), with div 0 behaving as 1.
REQ-015 SHALL, while en[i]=1, advance cnt[i] by 1 per cycle and wrap cnt[i] from d-1 to 0.
REQ-016 SHALL register tick[i] <= en[i] & (cnt[i]==d-1), giving 1-cycle latency and exactly one pulse per d enabled cycles.
REQ-017 SHALL register clk_out[i] <= (cnt[i] < d/2, floor) when en[i]=1; d=1 SHALL give constant 0, odd d SHALL give floor(d/2) high cycles.
REQ-018 SHALL, while en[i]=0, hold cnt[i] and clk_out[i] and drive tick[i]=0; re-enable SHALL resume from the held count.
REQ-019 SHALL, on wr with wr_ch<NCH, store wr_div in shadow[wr_ch] and set pending[wr_ch].
REQ-020 SHALL ignore any write with wr_ch>=NCH.
REQ-021 SHALL copy shadow to the active div and clear pending at the next wrap of that channel, or on the next cycle if en[i]=0.
REQ-022 SHALL, when wr coincides with a wrap of the same channel, load wr_div directly into the active div, leaving pending=0.
REQ-023 SHALL apply only the last of back-to-back writes to one channel before its wrap.
REQ-024 SHALL, on sync, clear all cnt and all tick, apply every pending shadow, and clear pending; a coincident wr SHALL be applied directly.
REQ-025 SHALL keep channels fully independent apart from sync and the shared write port.

Reset
REQ-026 SHALL, on resetn low, immediately set cnt=0, div=shadow=DEFAULT_DIV, pending=0, tick=0 and clk_out=0 on all channels.
REQ-027 SHALL make the first tick after reset release appear DEFAULT_DIV enabled cycles later.

Structure
REQ-028 SHALL put DEFAULT_DIV, the default CW and the channel-index width function in package clk_gen_pkg.
REQ-029 SHALL implement one channel (cnt, div, shadow, pending, tick, clk_out) as sub-module clk_div_chan, instantiated NCH times by generate.
REQ-030 SHALL keep write decode and sync fan-out in clk_div_bank.

Verification
REQ-031 SHALL check: reset release with en=4'b0001 -> tick[0] pulses every 12 cycles starting at cycle 12; clk_out[0] runs 6 high / 6 low.
REQ-032 SHALL check: wr ch1 div=5 at cnt=3 -> pending[1]=1 until the wrap at cnt=11, then period 5 with clk_out 2 high / 3 low.
REQ-033 SHALL check: wr ch2 div=0, then div=1 -> tick[2] high every cycle and clk_out[2] constant 0.
REQ-034 SHALL check: en[0] dropped for 7 cycles at cnt=4 -> no ticks, clk_out frozen, next tick 7 cycles after re-enable.
REQ-035 SHALL check: sync with ch3 pending div=8 -> all counters 0, ch3 period 8, all ticks re-aligned.
REQ-036 SHALL check: resetn pulsed low mid-count -> outputs 0 at once, divisors back to 12, pending cleared.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the clock-divider bank.
// Holds the default divisor, the default counter width and the channel-index width function.
package clk_gen_pkg;

    // The reset divisor of 12 gives one 8051 machine cycle per divided period.
    localparam int unsigned DEFAULT_DIV = 12;
    localparam int unsigned DEFAULT_CW  = 16;

    // Returns the width of a channel index. It is never below 1, so the port stays legal at NCH=1.
    function automatic int unsigned ch_idx_w(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: a wrapping counter, active and shadow divisors, and registered tick and
// square-wave outputs. A staged divisor takes effect only at a period boundary.
module clk_div_chan #(
    parameter int unsigned CW          = clk_gen_pkg::DEFAULT_CW,
    parameter int unsigned DEFAULT_DIV = clk_gen_pkg::DEFAULT_DIV
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_sync,
    input  logic          i_wr,
    input  logic [CW-1:0] i_wr_div,
    output logic          o_tick,
    output logic          o_clk_out,
    output logic          o_pending
);

    logic [CW-1:0] r_cnt, r_div, r_shadow;
    logic          r_pending, r_tick, r_clk_out;

    logic [CW-1:0] r_cnt_d, r_div_d, r_shadow_d;
    logic          r_pending_d, r_tick_d, r_clk_out_d;

    logic [CW-1:0] w_d;
    logic [CW-1:0] w_last;
    logic [CW-1:0] w_half;
    logic          w_at_end;
    logic          w_wrap;

    assign w_d    = (r_div == '0) ? CW'(1) : r_div;
    assign w_last = w_d - CW'(1);
    assign w_half = w_d >> 1;
    // ">=" rather than "==": if a divisor change leaves the count beyond the new end, the
    // channel still wraps on the next enabled cycle instead of running on to counter overflow.
    assign w_at_end = (r_cnt >= w_last);
    assign w_wrap   = i_en & w_at_end;

    always_comb begin
        r_cnt_d     = r_cnt;
        r_div_d     = r_div;
        r_shadow_d  = r_shadow;
        r_pending_d = r_pending;
        r_tick_d    = 1'b0;
        r_clk_out_d = r_clk_out;

        if (i_en) begin
            r_cnt_d     = w_wrap ? '0 : r_cnt + CW'(1);
            r_tick_d    = w_at_end;
            r_clk_out_d = (r_cnt < w_half);
        end

        if (i_sync) begin
            r_cnt_d     = '0;
            r_tick_d    = 1'b0;
            r_pending_d = 1'b0;
            if (r_pending) begin
                r_div_d = r_shadow;
            end
        end else if (w_wrap || !i_en) begin
            r_pending_d = 1'b0;
            if (r_pending) begin
                r_div_d = r_shadow;
            end
        end

        // A write on an apply boundary bypasses the shadow, so it never shows as pending.
        if (i_wr) begin
            r_shadow_d = i_wr_div;
            if (i_sync || w_wrap) begin
                r_div_d     = i_wr_div;
                r_pending_d = 1'b0;
            end else begin
                r_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_div     <= CW'(DEFAULT_DIV);
            r_shadow  <= CW'(DEFAULT_DIV);
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            r_cnt     <= r_cnt_d;
            r_div     <= r_div_d;
            r_shadow  <= r_shadow_d;
            r_pending <= r_pending_d;
            r_tick    <= r_tick_d;
            r_clk_out <= r_clk_out_d;
        end
    end

    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;
    assign o_pending = r_pending;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers sharing one divisor write port and a global sync restart.
// This module decodes the write target and fans the sync and write data out to the channels.
module clk_div_bank #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = clk_gen_pkg::DEFAULT_CW,
    parameter int unsigned DEFAULT_DIV = clk_gen_pkg::DEFAULT_DIV
) (
    input  logic                                   CLK,
    input  logic                                   resetn,
    input  logic [NCH-1:0]                         en,
    input  logic                                   sync,
    input  logic                                   wr,
    input  logic [clk_gen_pkg::ch_idx_w(NCH)-1:0]  wr_ch,
    input  logic [CW-1:0]                          wr_div,
    output logic [NCH-1:0]                         tick,
    output logic [NCH-1:0]                         clk_out,
    output logic [NCH-1:0]                         pending
);

    logic [NCH-1:0] w_wr_sel;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        // An out-of-range wr_ch matches no channel, so that write is dropped.
        assign w_wr_sel[g] = wr && (32'(wr_ch) == g);

        clk_div_chan #(
            .CW          (CW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .i_clk     (CLK),
            .i_rst_n   (resetn),
            .i_en      (en[g]),
            .i_sync    (sync),
            .i_wr      (w_wr_sel[g]),
            .i_wr_div  (wr_div),
            .o_tick    (tick[g]),
            .o_clk_out (clk_out[g]),
            .o_pending (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a linear sequence of steps with hand-computed expectations
// covering reset, divisor writes, zero/one divisors, enable gating, sync and asynchronous reset.
module tb_clk_div_bank;

    logic        CLK;
    logic        resetn;
    logic [3:0]  en;
    logic        sync;
    logic        wr;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic [3:0]  tick;
    logic [3:0]  clk_out;
    logic [3:0]  pending;

    int n_vec;
    int n_err;
    logic [3:0] exp4;

    clk_div_bank u_dut (
        .CLK     (CLK),
        .resetn  (resetn),
        .en      (en),
        .sync    (sync),
        .wr      (wr),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .tick    (tick),
        .clk_out (clk_out),
        .pending (pending)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        resetn = 1'b0;
        en     = 4'b0000;
        sync   = 1'b0;
        wr     = 1'b0;
        wr_ch  = 2'd0;
        wr_div = 16'd0;
        step();
        step();
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);

        // First period after reset release: tick[0] at cycle 12 and 24, clk_out[0] 6 high / 6 low.
        resetn = 1'b1;
        en     = 4'b0001;
        for (int k = 1; k <= 24; k++) begin
            step();
            check("a_tick", 32'(tick), (k % 12 == 0) ? 32'h1 : 32'h0);
            check("a_clk_out0", 32'(clk_out[0]), 32'(((k - 1) % 12) < 6));
        end

        // Channel 1: write div=5 while its count is 3; it applies at the wrap from 11.
        en = 4'b0011;
        repeat (3) step();
        wr     = 1'b1;
        wr_ch  = 2'd1;
        wr_div = 16'd5;
        step();
        wr = 1'b0;
        check("b_pending_set", 32'(pending), 32'h2);
        for (int k = 29; k <= 35; k++) begin
            step();
            check("b_pending_hold", 32'(pending[1]), 32'h1);
        end
        step();
        check("b_wrap_tick", 32'(tick), 32'h3);
        check("b_pending_clr", 32'(pending[1]), 32'h0);
        for (int m = 1; m <= 10; m++) begin
            step();
            check("b_tick1", 32'(tick[1]), 32'(m % 5 == 0));
            check("b_clk_out1", 32'(clk_out[1]), 32'(((m - 1) % 5) < 2));
        end

        // Channel 2: div=0 then div=1 back to back; both mean a divide-by-one.
        en     = 4'b0111;
        wr     = 1'b1;
        wr_ch  = 2'd2;
        wr_div = 16'd0;
        step();
        wr_div = 16'd1;
        step();
        wr = 1'b0;
        check("c_pending_set", 32'(pending[2]), 32'h1);
        repeat (9) step();
        check("c_pending_hold", 32'(pending[2]), 32'h1);
        check("c_tick_pre", 32'(tick[2]), 32'h0);
        for (int k = 58; k <= 63; k++) begin
            step();
            check("c_tick2", 32'(tick[2]), 32'h1);
            check("c_clk_out2", 32'(clk_out[2]), 32'h0);
            check("c_pending_clr", 32'(pending[2]), 32'h0);
        end

        // Channel 0: disable at count 4 for 7 cycles; next tick 7 cycles after re-enable.
        step();
        check("d_clk_out0_pre", 32'(clk_out[0]), 32'h1);
        en = 4'b0110;
        for (int k = 65; k <= 71; k++) begin
            step();
            check("d_tick0_off", 32'(tick[0]), 32'h0);
            check("d_clk_out0_frozen", 32'(clk_out[0]), 32'h1);
        end
        en = 4'b0111;
        for (int k = 72; k <= 79; k++) begin
            step();
            check("d_tick0_resume", 32'(tick[0]), 32'(k == 79));
        end

        // Sync with channel 3 holding a staged div=8.
        en     = 4'b1111;
        wr     = 1'b1;
        wr_ch  = 2'd3;
        wr_div = 16'd8;
        step();
        wr = 1'b0;
        check("e_pending_set", 32'(pending), 32'h8);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("e_sync_tick", 32'(tick), 32'h0);
        check("e_sync_pending", 32'(pending), 32'h0);
        for (int m = 1; m <= 12; m++) begin
            step();
            exp4 = {(m % 8 == 0), 1'b1, (m % 5 == 0), (m % 12 == 0)};
            check("e_tick_align", 32'(tick), 32'(exp4));
            check("e_clk_out3", 32'(clk_out[3]), 32'(((m - 1) % 8) < 4));
        end

        // Asynchronous reset mid-count with a divisor staged on channel 0.
        wr     = 1'b1;
        wr_ch  = 2'd0;
        wr_div = 16'd7;
        step();
        wr = 1'b0;
        check("f_pending_pre", 32'(pending), 32'h1);
        check("f_clk_out0_pre", 32'(clk_out[0]), 32'h1);
        #3;
        resetn = 1'b0;
        #1;
        check("f_async_tick", 32'(tick), 32'h0);
        check("f_async_clk_out", 32'(clk_out), 32'h0);
        check("f_async_pending", 32'(pending), 32'h0);
        step();
        check("f_held_tick", 32'(tick), 32'h0);
        en     = 4'b0011;
        resetn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("f_tick_default", 32'(tick), (k == 12) ? 32'h3 : 32'h0);
            check("f_pending_zero", 32'(pending), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
